machine_segscan: RTL and testbench

MACHINE_SEGSCAN -- requirements
Module: machine_segscan

---
 rtl/machine_segscan.sv | 133 +++++++++++++
 tb/tb_machine_segscan.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_segscan.sv
// Multiplexed hex 7-segment scanner with load-strobed shadow data; SEGSCAN_DIM_EN adds PWM dimming.
// Latency: outputs are registered, showing the index/shadow as they stood one edge earlier.
// Backpressure: none; load is a strobe, and enable low freezes the scan and blanks the display.
module machine_segscan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
`ifdef SEGSCAN_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segments,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_dp;
  logic                  slot_tick;
  logic                  lit;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [DIGITS-1:0]     sel_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_tick = enable && (presc == PRESC_LAST);

`ifdef SEGSCAN_DIM_EN
  logic [3:0] phase;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      phase <= 4'd0;
    end else if (enable) begin
      phase <= phase + 4'd1;
    end
  end

  // Phase 0..brightness inclusive is lit, so brightness 0 still gives 1/16 duty.
  assign lit = (phase <= brightness);
`else
  assign lit = 1'b1;
`endif

  // Digit select and data mux for the current index.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    sel_n   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib  = shadow_val[4*k +: 4];
        cur_dp   = shadow_dp[k];
        sel_n[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      presc      <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      if (enable) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end
      if (slot_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
    end
  end

  // Output stage decodes pre-edge state, so a load landing with slot_tick shows up together with the new index.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      anode      <= '1;
      segments   <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= slot_tick && (idx == IDX_LAST);
      if (enable) begin
        anode    <= lit ? sel_n : '1;
        segments <= hex7(cur_nib);
        dp_n     <= ~cur_dp;
      end else begin
        anode    <= '1;
        segments <= 7'h7F;
        dp_n     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_machine_segscan.sv
// Bench for machine_segscan: a 4-digit/DIV=3 and a 1-digit/DIV=1 instance share one stimulus stream.
module tb_machine_segscan;

  logic        sys_clk;
  logic        sys_rstn;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  bright;

  logic [3:0]  anode_a;
  logic [6:0]  seg_a;
  logic        dpn_a, ft_a;
  logic [0:0]  anode_b;
  logic [6:0]  seg_b;
  logic        dpn_b, ft_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  machine_segscan #(.DIGITS(4), .DIV(3)) dut_a (
    .system1000      (sys_clk),
    .system1000_rstn (sys_rstn),
    .enable          (enable),
    .load            (load),
    .value           (value),
    .dp              (dp),
`ifdef SEGSCAN_DIM_EN
    .brightness      (bright),
`endif
    .anode           (anode_a),
    .segments        (seg_a),
    .dp_n            (dpn_a),
    .frame_tick      (ft_a)
  );

  machine_segscan #(.DIGITS(1), .DIV(1)) dut_b (
    .system1000      (sys_clk),
    .system1000_rstn (sys_rstn),
    .enable          (enable),
    .load            (load),
    .value           (value[3:0]),
    .dp              (dp[0:0]),
`ifdef SEGSCAN_DIM_EN
    .brightness      (4'hF),
`endif
    .anode           (anode_b),
    .segments        (seg_b),
    .dp_n            (dpn_b),
    .frame_tick      (ft_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the scan position is a pure function of how many enabled edges have passed since reset.
  logic [6:0]  seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          ec = 0;
  int          d;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_dp = '0;
  logic [3:0]  e_an_a = 4'hF;
  logic [6:0]  e_seg_a = 7'h7F;
  logic        e_dpn_a = 1'b1, e_ft_a = 1'b0;
  logic        e_an_b = 1'b1;
  logic [6:0]  e_seg_b = 7'h7F;
  logic        e_dpn_b = 1'b1, e_ft_b = 1'b0;

  always @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ec = 0; sh_val = '0; sh_dp = '0;
      e_an_a = 4'hF; e_seg_a = 7'h7F; e_dpn_a = 1'b1; e_ft_a = 1'b0;
      e_an_b = 1'b1; e_seg_b = 7'h7F; e_dpn_b = 1'b1; e_ft_b = 1'b0;
    end else begin
      if (enable) begin
        d = (ec / 3) % 4;
        e_an_a  = ~(4'b0001 << d);
`ifdef SEGSCAN_DIM_EN
        if ((ec % 16) > int'(bright)) e_an_a = 4'hF;
`endif
        e_seg_a = seg_ref[sh_val[4*d +: 4]];
        e_dpn_a = ~sh_dp[d];
        e_ft_a  = ((ec + 1) % 12) == 0;
        e_an_b  = 1'b0;
        e_seg_b = seg_ref[sh_val[3:0]];
        e_dpn_b = ~sh_dp[0];
        e_ft_b  = 1'b1;
        ec = ec + 1;
      end else begin
        e_an_a = 4'hF; e_seg_a = 7'h7F; e_dpn_a = 1'b1; e_ft_a = 1'b0;
        e_an_b = 1'b1; e_seg_b = 7'h7F; e_dpn_b = 1'b1; e_ft_b = 1'b0;
      end
      if (load) begin
        sh_val = value;
        sh_dp  = dp;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      check("m_anode_a", 32'(anode_a), 32'(e_an_a));
      check("m_seg_a",   32'(seg_a),   32'(e_seg_a));
      check("m_dpn_a",   32'(dpn_a),   32'(e_dpn_a));
      check("m_ft_a",    32'(ft_a),    32'(e_ft_a));
      check("m_anode_b", 32'(anode_b), 32'(e_an_b));
      check("m_seg_b",   32'(seg_b),   32'(e_seg_b));
      check("m_dpn_b",   32'(dpn_b),   32'(e_dpn_b));
      check("m_ft_b",    32'(ft_b),    32'(e_ft_b));
    end
  end

  logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] sg_lit [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};

  initial begin
    int   cnt;
    int   dd;
    bit   found;
    logic [3:0] an_exp;

    sys_rstn = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0; bright = 4'hF;
    repeat (2) @(negedge sys_clk);
    check("rst_anode_a", 32'(anode_a), 32'h0000000F);
    check("rst_seg_a",   32'(seg_a),   32'h0000007F);
    check("rst_dpn_a",   32'(dpn_a),   32'h1);
    check("rst_ft_a",    32'(ft_a),    32'h0);
    check("rst_anode_b", 32'(anode_b), 32'h1);
    chk_on = 1'b1;

    // 1A2F loaded while disabled, then scanned.
    load = 1'b1; value = 16'h1A2F; dp = 4'b0000;
    #2 sys_rstn = 1'b1;
    @(negedge sys_clk);
    load = 1'b0; enable = 1'b1;
    check("b_ft_first", 32'(ft_b), 32'h0);
    for (int c = 1; c <= 24; c++) begin
      @(negedge sys_clk);
      check("scan_anode", 32'(anode_a), 32'(an_lit[((c - 1) / 3) % 4]));
      check("scan_seg",   32'(seg_a),   32'(sg_lit[((c - 1) / 3) % 4]));
      check("scan_ft",    32'(ft_a),    32'((c % 12) == 0));
      check("b_anode",    32'(anode_b), 32'h0);
      check("b_ft",       32'(ft_b),    32'h1);
    end

    // New data and a dp on digit 2 loaded while digit 1 is on screen.
    repeat (4) @(negedge sys_clk);
    load = 1'b1; value = 16'h0000; dp = 4'b0100;
    @(negedge sys_clk);
    load = 1'b0;
    @(negedge sys_clk);
    check("ld_anode", 32'(anode_a), 32'hD);
    check("ld_seg",   32'(seg_a),   32'h40);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      check("ld_dpn", 32'(dpn_a), 32'(anode_a != 4'b1011));
      if (anode_a == 4'b1011) cnt++;
    end
    check("ld_dp_cycles", 32'(cnt), 32'd3);

    // Freeze for 10 cycles at the start of a slot; the same digit then finishes its 2 remaining cycles.
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (ec % 3 == 1) found = 1'b1;
      else @(negedge sys_clk);
    end
    check("freeze_align", 32'(found), 32'h1);
    dd = ((ec - 1) / 3) % 4;
    an_exp = ~(4'b0001 << dd);
    check("freeze_pre", 32'(anode_a), 32'(an_exp));
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      check("frz_anode", 32'(anode_a), 32'hF);
      check("frz_seg",   32'(seg_a),   32'h7F);
      check("frz_ft",    32'(ft_a),    32'h0);
    end
    enable = 1'b1;
    repeat (2) begin
      @(negedge sys_clk);
      check("resume_same", 32'(anode_a), 32'(an_exp));
    end
    @(negedge sys_clk);
    an_exp = ~(4'b0001 << ((dd + 1) % 4));
    check("resume_next", 32'(anode_a), 32'(an_exp));

    // Asynchronous reset between edges in mid-frame.
    @(negedge sys_clk);
    #2 sys_rstn = 1'b0;
    #1;
    check("arst_anode", 32'(anode_a), 32'hF);
    check("arst_seg",   32'(seg_a),   32'h7F);
    check("arst_dpn",   32'(dpn_a),   32'h1);
    check("arst_ft",    32'(ft_a),    32'h0);
    @(negedge sys_clk);
    #2 sys_rstn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge sys_clk);
      check("post_rst_anode", 32'(anode_a), (c <= 3) ? 32'hE : 32'hD);
      check("post_rst_seg",   32'(seg_a),   32'h40);
    end

`ifdef SEGSCAN_DIM_EN
    bright = 4'd3;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      if (anode_a != 4'hF) cnt++;
    end
    check("dim3_on_cycles", 32'(cnt), 32'd4);
    bright = 4'd15;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      if (anode_a != 4'hF) cnt++;
    end
    check("dim15_on_cycles", 32'(cnt), 32'd16);
`endif

    // Random traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      enable = ($urandom % 8) != 0;
      load   = ($urandom % 4) == 0;
      value  = 16'($urandom);
      dp     = 4'($urandom);
      bright = 4'($urandom);
      if ($urandom % 150 == 0) begin
        #3 sys_rstn = 1'b0;
        #4 sys_rstn = 1'b1;
      end
    end
    @(negedge sys_clk);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
